// File: rtl/binarization_pkg.sv
// Shared types and constants for the adaptive binarization threshold controller.
package binarization_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDivide,
    StUpdate
  } state_e;

  localparam int unsigned SUM_W      = 25;
  localparam int unsigned CNT_W      = 17;
  localparam int unsigned GRAY_WR    = 5;
  localparam int unsigned GRAY_WG    = 9;
  localparam int unsigned GRAY_WB    = 2;
  localparam int unsigned GRAY_SHIFT = 4;

  // Each weighted term is truncated on its own before summing.
  function automatic logic [7:0] rgb_to_gray(input logic [23:0] px);
    logic [11:0] r_term;
    logic [11:0] g_term;
    logic [11:0] b_term;
    r_term = 12'(32'(px[23:16]) * GRAY_WR) >> GRAY_SHIFT;
    g_term = 12'(32'(px[15:8]) * GRAY_WG) >> GRAY_SHIFT;
    b_term = 12'(32'(px[7:0]) * GRAY_WB) >> GRAY_SHIFT;
    return 8'(r_term + g_term + b_term);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, done asserted during the final step.
module seq_divider
  import binarization_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  localparam int unsigned STEP_W = $clog2(SUM_W + 1);

  logic [SUM_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W:0]    rem_shift;
  logic [CNT_W:0]    diff;

  always_comb begin
    rem_shift = {rem_q, quo_q[SUM_W-1]};
    diff      = rem_shift - {1'b0, divisor};
    quo_d     = quo_q;
    rem_d     = rem_q;
    step_d    = step_q;
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      step_d = STEP_W'(SUM_W);
    end else if (step_q != '0) begin
      step_d = step_q - STEP_W'(1);
      if (rem_shift >= {1'b0, divisor}) begin
        rem_d = diff[CNT_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[CNT_W-1:0];
        quo_d = {quo_q[SUM_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      step_q <= '0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      step_q <= step_d;
    end
  end

  assign quotient = quo_q;
  assign done     = (step_q == STEP_W'(1));

endmodule

// File: rtl/binarization_thresh_ctrl.sv
// Frame-mean adaptive threshold: accumulate gray over a full frame, divide, bias, clamp.
module binarization_thresh_ctrl
  import binarization_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned THRESHOLD  = 128,
  parameter int          OFFSET     = 0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] h_cnt,
  input  logic [10:0] v_cnt,
  input  logic [23:0] rgb,
  input  logic        adaptive_en,
  input  logic [7:0]  manual_thresh,
  output logic [7:0]  thresh_out,
  output logic        thresh_valid,
  output logic        busy
);

  localparam int unsigned FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam logic signed [SUM_W+1:0] OFFSET_EXT = (SUM_W + 2)'(OFFSET);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] div_quotient;
  logic [7:0]       gray;
  logic             active, fs, fe;
  logic signed [SUM_W+1:0] biased;
  logic [7:0]       new_thresh;

  assign gray   = rgb_to_gray(rgb);
  assign active = (32'(h_cnt) < IMG_WIDTH) && (32'(v_cnt) < IMG_HEIGHT);
  assign fs     = (h_cnt == '0) && (v_cnt == '0);
  assign fe     = (h_cnt == '0) && (32'(v_cnt) == IMG_HEIGHT);

  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fs) begin
          state_d = StAccum;
          sum_d   = SUM_W'(gray);
          cnt_d   = CNT_W'(1);
        end
      end
      StAccum: begin
        if (fs) begin
          sum_d = SUM_W'(gray);
          cnt_d = CNT_W'(1);
        end else if (fe) begin
          // A frame missing any active pixel is discarded rather than averaged.
          if (cnt_q == CNT_W'(FRAME_PIX)) begin
            state_d   = StDivide;
            div_start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (active) begin
          sum_d = sum_q + SUM_W'(gray);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDivide: begin
        if (div_done) state_d = StUpdate;
      end
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  seq_divider u_seq_divider (
    .clk      (pclk),
    .rst      (rst),
    .start    (div_start),
    .dividend (sum_q),
    .divisor  (CNT_W'(FRAME_PIX)),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_comb begin
    biased = $signed({2'b00, div_quotient}) + OFFSET_EXT;
    if (biased < 0) begin
      new_thresh = 8'd0;
    end else if (biased > 255) begin
      new_thresh = 8'd255;
    end else begin
      new_thresh = biased[7:0];
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= StIdle;
      sum_q        <= '0;
      cnt_q        <= '0;
      thresh_out   <= 8'(THRESHOLD);
      thresh_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      thresh_valid <= 1'b0;
      if (!adaptive_en) begin
        thresh_out <= manual_thresh;
      end else if (state_q == StUpdate) begin
        thresh_out   <= new_thresh;
        thresh_valid <= 1'b1;
      end
    end
  end

  assign busy = (state_q == StDivide) || (state_q == StUpdate);

endmodule

// File: tb/tb_binarization_thresh_ctrl.sv
// Directed frames on three offset variants; a scoreboard pairs each FE with its threshold pulse.
module tb_binarization_thresh_ctrl;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int HT = W + 4;
  localparam int VT = H + 2;

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic [23:0] rgb;
  logic        adaptive_en;
  logic [7:0]  manual_thresh;
  logic [7:0]  th0, thp, thn;
  logic        v0, vp, vn;
  logic        b0, bp, bn;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    int e0;
    int ep;
    int en;
    int due;
  } exp_t;
  exp_t sb[$];

  always #5 pclk = ~pclk;
  always @(posedge pclk) edge_cnt++;

  binarization_thresh_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(128), .OFFSET(0)) u_dut0 (
    .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .rgb(rgb), .adaptive_en(adaptive_en),
    .manual_thresh(manual_thresh), .thresh_out(th0), .thresh_valid(v0), .busy(b0)
  );
  binarization_thresh_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(128), .OFFSET(10)) u_dutp (
    .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .rgb(rgb), .adaptive_en(adaptive_en),
    .manual_thresh(manual_thresh), .thresh_out(thp), .thresh_valid(vp), .busy(bp)
  );
  binarization_thresh_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESHOLD(128), .OFFSET(-10)) u_dutn (
    .pclk(pclk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .rgb(rgb), .adaptive_en(adaptive_en),
    .manual_thresh(manual_thresh), .thresh_out(thn), .thresh_valid(vn), .busy(bn)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge pclk) begin
    exp_t e;
    if (v0 === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(v0), 32'd0);
      end else begin
        e = sb.pop_front();
        check("valid_timing", edge_cnt, e.due);
        check("thresh_off0", 32'(th0), e.e0);
        check("thresh_offp10", 32'(thp), e.ep);
        check("thresh_offm10", 32'(thn), e.en);
        check("valid_offp10", 32'(vp), 32'd1);
        check("valid_offm10", 32'(vn), 32'd1);
      end
    end
  end

  task automatic tick(input int h, input int v, input logic [23:0] px);
    h_cnt = 12'(h);
    v_cnt = 11'(v);
    rgb   = px;
    @(posedge pclk);
    #1;
  endtask

  task automatic blank();
    tick(HT - 1, VT - 1, 24'h0);
  endtask

  task automatic drive_lines(input int vs, input int ve, input logic [23:0] top,
                             input logic [23:0] bot, input int split, input int skip);
    for (int v = vs; v < ve; v++) begin
      if (v != skip) begin
        for (int h = 0; h < HT; h++) tick(h, v, (v < split) ? top : bot);
      end
    end
  endtask

  // Active lines, then FE (optionally scored), then the vertical blanking tail.
  task automatic frame(input logic [23:0] top, input logic [23:0] bot, input int split,
                       input int skip, input bit push, input bit div_exp,
                       input int e0, input int ep, input int en);
    exp_t e;
    drive_lines(0, H, top, bot, split, skip);
    tick(0, H, 24'h0);
    if (push) begin
      e = '{e0, ep, en, edge_cnt + 26};
      sb.push_back(e);
    end
    check("busy_after_fe", 32'(b0), 32'(div_exp));
    for (int h = 1; h < HT; h++) tick(h, H, 24'h0);
    drive_lines(H + 1, VT, 24'h0, 24'h0, 0, -1);
  endtask

  initial begin
    rst           = 1'b1;
    adaptive_en   = 1'b1;
    manual_thresh = 8'h00;
    blank();
    blank();
    check("rst_thresh0", 32'(th0), 32'd128);
    check("rst_threshp", 32'(thp), 32'd128);
    check("rst_threshn", 32'(thn), 32'd128);
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_busy", 32'(b0), 32'd0);
    rst = 1'b0;
    blank();

    frame(24'h808080, 24'h808080, H, -1, 1'b1, 1'b1, 128, 138, 118);
    frame(24'hFFFFFF, 24'hFFFFFF, H, -1, 1'b1, 1'b1, 253, 255, 243);
    frame(24'h000000, 24'h000000, H, -1, 1'b1, 1'b1, 0, 10, 0);

    // Reset while the divider is mid-flight.
    drive_lines(0, H, 24'h808080, 24'h808080, H, -1);
    tick(0, H, 24'h0);
    check("busy_in_divide", 32'(b0), 32'd1);
    for (int h = 1; h < 6; h++) tick(h, H, 24'h0);
    rst = 1'b1;
    tick(6, H, 24'h0);
    rst = 1'b0;
    check("rst_div_thresh", 32'(th0), 32'd128);
    check("rst_div_valid", 32'(v0), 32'd0);
    check("rst_div_busy", 32'(b0), 32'd0);
    for (int h = 7; h < HT; h++) tick(h, H, 24'h0);
    drive_lines(H + 1, VT, 24'h0, 24'h0, 0, -1);

    frame(24'hFFFFFF, 24'h000000, H / 2, -1, 1'b1, 1'b1, 126, 136, 116);

    // Early FS restarts the accumulation; only the following full frame counts.
    drive_lines(0, 5, 24'hFFFFFF, 24'hFFFFFF, H, -1);
    frame(24'h808080, 24'h808080, H, -1, 1'b1, 1'b1, 128, 138, 118);

    // Missing line 3: FE arrives with a short count, so no update.
    frame(24'hFFFFFF, 24'hFFFFFF, H, 3, 1'b0, 1'b0, 0, 0, 0);
    check("trunc_thresh", 32'(th0), 32'd128);
    check("trunc_valid", 32'(v0), 32'd0);

    adaptive_en   = 1'b0;
    manual_thresh = 8'h40;
    check("manual_pre_edge", 32'(th0), 32'd128);
    blank();
    check("manual_delay", 32'(th0), 32'h40);
    check("manual_delayp", 32'(thp), 32'h40);
    frame(24'hFFFFFF, 24'hFFFFFF, H, -1, 1'b0, 1'b1, 0, 0, 0);
    check("manual_hold", 32'(th0), 32'h40);
    check("manual_no_valid", 32'(v0), 32'd0);

    adaptive_en = 1'b1;
    blank();
    check("reenable_hold", 32'(th0), 32'h40);
    frame(24'hFFFFFF, 24'hFFFFFF, H, -1, 1'b1, 1'b1, 253, 255, 243);
    check("reenable_update", 32'(th0), 32'd253);

    for (int i = 0; i < 100 && sb.size() != 0; i++) blank();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binarization_thresh_ctrl.md
BINARIZATION_THRESH_CTRL -- requirements
Module: binarization_thresh_ctrl

Interface
REQ-001 Parameters SHALL be: IMG_WIDTH, default 320, active pixels per line; IMG_HEIGHT, default 240, active lines per frame; THRESHOLD, default 128, reset/initial threshold; OFFSET, default 0, signed bias in -255..255 added to the frame mean.
REQ-002 pclk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 h_cnt  in  12  horizontal pixel counter; one pixel per pclk.
REQ-005 v_cnt  in  11  vertical line counter.
REQ-006 rgb  in  24  pixel as R[23:16], G[15:8], B[7:0].
REQ-007 adaptive_en  in  1  1 = computed threshold; 0 = manual_thresh.
REQ-008 manual_thresh  in  8  threshold used when adaptive_en = 0.
REQ-009 thresh_out  out  8  registered threshold driving the binarization datapath.
REQ-010 thresh_valid  out  1  one-cycle pulse when thresh_out takes a new adaptive value.
REQ-011 busy  out  1  high in DIVIDE and UPDATE.

Function
REQ-012 Gray SHALL be computed as floor(R*5/16) + floor(G*9/16) + floor(B*2/16), with each term truncated separately; the result is 8 bits.
REQ-013 A pixel is active when h_cnt < IMG_WIDTH and v_cnt < IMG_HEIGHT.
REQ-014 Frame start (FS) is any cycle with h_cnt = 0 and v_cnt = 0.
REQ-015 Frame end (FE) is the cycle with h_cnt = 0 and v_cnt = IMG_HEIGHT.
REQ-016 FSM states SHALL be IDLE, ACCUM, DIVIDE and UPDATE.
REQ-017 IDLE -> ACCUM on FS; the FS-cycle pixel is the first pixel accumulated.
REQ-018 In ACCUM, every active pixel SHALL add its gray value to a 25-bit sum and increment a 17-bit pixel count.
REQ-019 FS arriving in ACCUM SHALL clear sum and count, then accumulate the FS-cycle pixel (restart).
REQ-020 On FE in ACCUM: if count = IMG_WIDTH*IMG_HEIGHT go to DIVIDE; otherwise go to IDLE with no update (truncated frame discarded).
REQ-021 DIVIDE SHALL compute mean = floor(sum / (IMG_WIDTH*IMG_HEIGHT)) by restoring division.
  - Exactly 25 cycles.
  - Then UPDATE for 1 cycle, then IDLE.
REQ-022 FS during DIVIDE or UPDATE SHALL be ignored; that frame is not accumulated.
REQ-023 New threshold SHALL be mean + OFFSET, computed signed, clamped to 0..255.
REQ-024 In UPDATE, if adaptive_en = 1, the new threshold is registered into thresh_out and thresh_valid pulses the next cycle.
  - Timing: FE at cycle N gives thresh_out/thresh_valid at N+27.
REQ-025 When adaptive_en = 0, thresh_out SHALL equal manual_thresh delayed one cycle; the FSM still runs, and UPDATE neither changes thresh_out nor pulses thresh_valid.
REQ-026 On an adaptive_en 0 -> 1 transition, thresh_out SHALL hold the last manual value until the next UPDATE.
REQ-027 Sum width SHALL not overflow: 255 * 76800 < 2^25.

Reset
REQ-028 On rst: state = IDLE; sum, count and divider cleared; thresh_out = THRESHOLD; thresh_valid = 0; busy = 0.
REQ-029 rst mid-ACCUM or mid-DIVIDE SHALL abort the operation; no partial result is ever output.

Structure
REQ-030 Package binarization_pkg SHALL hold: the FSM state enum, SUM_W = 25, CNT_W = 17, and gray weights 5/9/2 with shift 4.
REQ-031 Sub-module seq_divider SHALL be instantiated:
  - 25-bit dividend, 17-bit divisor.
  - start/done handshake, fixed 25-cycle latency.
  - Synchronous active-high reset.

Verification
REQ-032 Full frame of rgb = 0x808080, OFFSET = 0 -> thresh_out = 128, thresh_valid at FE + 27 cycles.
REQ-033 Full frame of 0xFFFFFF (gray 253), OFFSET = +10 -> thresh_out = 255 (clamped).
  - All-black frame with OFFSET = -10 -> thresh_out = 0.
REQ-034 Lines 0-119 = 0xFFFFFF, lines 120-239 = 0x000000, OFFSET = 0 -> mean 126, thresh_out = 126.
REQ-035 v_cnt restarts at line 100 (early FS), then a complete frame of 0x808080 -> first frame discarded, no pulse; second frame yields 128.
  - Separately, a frame where FE is reached with count < 76800 -> no update, thresh_valid stays 0.
REQ-036 rst asserted mid-DIVIDE -> thresh_out = 128, thresh_valid = 0.
  - adaptive_en = 0 with manual_thresh = 0x40 -> thresh_out = 0x40 one cycle later, no pulse at UPDATE.
